// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: paces cnvst, averages 2^avg_log2 results with rounding,
// and buffers them in a first-word-fall-through FIFO with sticky overflow/timeout flags.
module sar_conv_sequencer #(
    parameter int PERIOD_W   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [PERIOD_W-1:0]         period,
    input  logic [1:0]                  avg_log2,
    input  logic                        err_clr,
    output logic                        cnvst,
    input  logic [7:0]                  sar_in,
    input  logic                        eoc_in,
    output logic [7:0]                  dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        timeout_err,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_EOC, HOLD} state_t;

    state_t              state, state_nx;
    logic [PERIOD_W-1:0] icnt, icnt_nx, icnt_inc;
    logic [TW-1:0]       tcnt, tcnt_nx;
    logic [10:0]         acc, acc_nx;
    logic [2:0]          cnt, cnt_nx;
    logic [1:0]          avg_q, avg_nx;
    logic                push_req, to_set;

    logic [3:0]  win_len;
    logic        win_last;
    logic [11:0] rnd, sum, shifted;
    logic [7:0]  result;
    logic        hold_done, timed_out;

    assign win_len  = 4'd1 << avg_q;
    assign win_last = ({1'b0, cnt} == win_len - 4'd1);

    always_comb begin
        case (avg_q)
            2'd0:    rnd = 12'd0;
            2'd1:    rnd = 12'd1;
            2'd2:    rnd = 12'd2;
            default: rnd = 12'd4;
        endcase
    end

    assign sum     = {1'b0, acc} + {4'b0, sar_in} + rnd;
    assign shifted = sum >> avg_q;
    assign result  = (shifted > 12'd255) ? 8'hFF : shifted[7:0];

    // icnt/tcnt hold the number of cycles elapsed since the cnvst pulse, so the
    // START cycle loads 1 and HOLD exits exactly `period` cycles after cnvst.
    assign icnt_inc  = (icnt == '1) ? icnt : icnt + PERIOD_W'(1);
    assign hold_done = ({1'b0, icnt} + (PERIOD_W+1)'(1)) >= {1'b0, period};
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    assign cnvst = (state == START);
    assign busy  = (state != IDLE);

    always_comb begin
        state_nx = state;
        icnt_nx  = icnt;
        tcnt_nx  = tcnt;
        acc_nx   = acc;
        cnt_nx   = cnt;
        avg_nx   = avg_q;
        push_req = 1'b0;
        to_set   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    avg_nx   = avg_log2;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                icnt_nx  = PERIOD_W'(1);
                tcnt_nx  = TW'(1);
                state_nx = WAIT_EOC;
            end
            WAIT_EOC: begin
                icnt_nx = icnt_inc;
                tcnt_nx = tcnt + TW'(1);
                if (eoc_in) begin
                    state_nx = HOLD;
                    if (win_last) begin
                        push_req = 1'b1;
                        acc_nx   = '0;
                        cnt_nx   = '0;
                        avg_nx   = avg_log2;
                    end else begin
                        acc_nx = acc + {3'b0, sar_in};
                        cnt_nx = cnt + 3'd1;
                    end
                end else if (timed_out) begin
                    to_set   = 1'b1;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                icnt_nx = icnt_inc;
                if (hold_done) begin
                    if (enable) begin
                        state_nx = START;
                    end else begin
                        acc_nx   = '0;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            icnt  <= '0;
            tcnt  <= '0;
            acc   <= '0;
            cnt   <= '0;
            avg_q <= '0;
        end else begin
            state <= state_nx;
            icnt  <= icnt_nx;
            tcnt  <= tcnt_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            avg_q <= avg_nx;
        end
    end

    // Result FIFO; a push into a full FIFO only lands if the head leaves the same cycle.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, do_push, do_pop, ovf_set;

    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign dout_valid = (fifo_level != '0);
    assign do_pop     = dout_valid & dout_ready;
    assign do_push    = push_req & (~full | do_pop);
    assign ovf_set    = push_req & full & ~do_pop;
    assign dout       = dout_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            overflow    <= ovf_set | (overflow & ~err_clr);
            timeout_err <= to_set | (timeout_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for sar_conv_sequencer: SAR reply model, scoreboard monitor on the FIFO output,
// directed scenarios for pacing, averaging, overflow, timeout, enable drop and async reset.
module tb_sar_conv_sequencer;

    localparam int PERIOD_W   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] period = 8'd0;
    logic [1:0] avg_log2 = 2'd0;
    logic       err_clr = 1'b0;
    logic       cnvst;
    logic [7:0] sar_in = 8'd0;
    logic       eoc_in = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow, timeout_err, busy;

    int         n_chk = 0, n_fail = 0, n_pops = 0, cyc = 0;
    int         k, base, pops0, c, c2;
    logic [7:0] exp_q[$];
    logic [7:0] sar_q[$];
    int         cnv_times[$];
    int         sar_delay = 20;
    bit         sar_mute = 1'b0;

    sar_conv_sequencer #(.PERIOD_W(PERIOD_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .avg_log2(avg_log2),
        .err_clr(err_clr), .cnvst(cnvst), .sar_in(sar_in), .eoc_in(eoc_in), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .fifo_level(fifo_level),
        .overflow(overflow), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cnvst) cnv_times.push_back(cyc);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cnv(input int n);
        int w = 0;
        while (cnv_times.size() < n && w < 400) begin
            @(negedge clk); #1;
            w++;
        end
        chk("cnvst_seen", cnv_times.size() >= n, 1);
    endtask

    task automatic wait_empty(input string nm);
        int w = 0;
        while (fifo_level != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk(nm, fifo_level, 0);
    endtask

    // SAR model: eoc arrives sar_delay cycles after the cnvst pulse
    initial forever begin
        @(negedge clk);
        if (cnvst && !sar_mute) begin
            repeat (sar_delay) @(posedge clk);
            #1;
            eoc_in = 1'b1;
            sar_in = (sar_q.size() > 0) ? sar_q.pop_front() : 8'h00;
            @(posedge clk); #1;
            eoc_in = 1'b0;
            sar_in = 8'h00;
        end
    end

    // Scoreboard monitor: every accepted head must match the next expected result
    initial forever begin
        @(negedge clk);
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
            else begin
                chk("sb_dout", dout, exp_q.pop_front());
                n_pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        period = 8'd40;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnvst", cnvst, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // single conversion, pacing, then enable drop mid-conversion
        sar_delay = 20;
        sar_q.push_back(8'hA5); sar_q.push_back(8'h3C);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        enable = 1'b1;
        k = 0;
        while (!dout_valid && k < 100) begin @(negedge clk); k++; end
        chk("t1_valid", dout_valid, 1);
        chk("t1_latency", cyc - cnv_times[0], 21);
        chk("t1_dout", dout, 8'hA5);
        chk("t1_level", fifo_level, 1);
        chk("t1_one_pulse", cnv_times.size(), 1);
        wait_cnv(2);
        chk("t1_interval", cnv_times[1] - cnv_times[0], 40);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_no_cnvst", cnv_times.size(), 2);
        chk("t1_level2", fifo_level, 2);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        wait_empty("t1_drained");

        // 4-sample average with rounding; avg_log2 change mid-window ignored
        base = cnv_times.size();
        pops0 = n_pops;
        @(posedge clk); #1;
        period = 8'd0; sar_delay = 3; avg_log2 = 2'd2;
        sar_q.push_back(8'd10); sar_q.push_back(8'd11);
        sar_q.push_back(8'd11); sar_q.push_back(8'd11);
        exp_q.push_back(8'd11);
        enable = 1'b1;
        wait_cnv(base + 2);
        @(posedge clk); #1;
        avg_log2 = 2'd0;
        wait_cnv(base + 4);
        chk("t2_no_early_push", n_pops, pops0);
        chk("t2_level0", fifo_level, 0);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("t2_busy", busy, 0);
        chk("t2_one_push", n_pops, pops0 + 1);
        chk("t2_cnv_count", cnv_times.size(), base + 4);

        // overflow, then push while full with a simultaneous pop
        base = cnv_times.size();
        @(posedge clk); #1;
        dout_ready = 1'b0;
        for (int i = 1; i <= 5; i++) sar_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        enable = 1'b1;
        wait_cnv(base + 5);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("t3_level_full", fifo_level, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_head", dout, 1);
        chk("t3_busy", busy, 0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clr", overflow, 0);
        sar_q.push_back(8'd6);
        exp_q.push_back(8'd6);
        @(posedge clk); #1;
        enable = 1'b1;
        k = 0;
        do begin @(posedge clk); #2; k++; end while (!eoc_in && k < 30);
        chk("t3_eoc_seen", eoc_in, 1);
        dout_ready = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("t3_full_before", fifo_level, 4);
        @(negedge clk);
        chk("t3_pushpop_level", fifo_level, 4);
        chk("t3_no_ovf", overflow, 0);
        wait_empty("t3_drained");

        // timeout, err_clr, and err_clr coincident with a new timeout
        base = cnv_times.size();
        @(posedge clk); #1;
        sar_mute = 1'b1;
        enable = 1'b1;
        wait_cnv(base + 1);
        c = cnv_times[base];
        k = 0;
        while (!timeout_err && k < 200) begin @(negedge clk); k++; end
        chk("t4_flag", timeout_err, 1);
        chk("t4_time", cyc - c, TIMEOUT);
        chk("t4_no_push", fifo_level, 0);
        wait_cnv(base + 2);
        chk("t4_reissue", cnv_times[base + 1] - c, TIMEOUT + 1);
        c2 = cnv_times[base + 1];
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_clr", timeout_err, 0);
        while (cyc < c2 + TIMEOUT - 1) begin @(posedge clk); #1; end
        err_clr = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", timeout_err, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_busy", busy, 0);
        sar_mute = 1'b0;

        // asynchronous reset while waiting for eoc
        base = cnv_times.size();
        @(posedge clk); #1;
        dout_ready = 1'b0;
        sar_delay = 5;
        sar_q.push_back(8'h77);
        exp_q.push_back(8'h77);
        enable = 1'b1;
        wait_cnv(base + 2);
        @(posedge clk); #1;
        chk("t5_level_pre", fifo_level, 1);
        chk("t5_busy_pre", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_cnvst", cnvst, 0);
        chk("t5_valid", dout_valid, 0);
        chk("t5_dout", dout, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_tmo", timeout_err, 0);
        chk("t5_ovf", overflow, 0);
        exp_q.delete();
        enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t5_stay_idle", busy, 0);
        chk("t5_stray_eoc", fifo_level, 0);
        chk("t5_no_cnvst", cnv_times.size(), base + 2);

        chk("sb_all_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
